// File: rtl/fma_align_add_if.sv
`default_nettype none
// ============================================================================
//  Module   : fma_align_add_if
//  Purpose  : Bundles the operand-in / result-out signals of the FMA
//             alignment-and-add stage.
//  Ports    : master - multiplier/test side (drives operands, reads results)
//             slave  - fma_align_add side (reads operands, drives results)
//  Revision : 1.0 - initial release
// ============================================================================
interface fma_align_add_if;
    logic        align_start;        // operand-valid pulse
    logic [21:0] mantissa_ab_in;     // product significand, 2.20 fixed point
    logic [4:0]  exp_ab_in;          // biased product exponent
    logic        sign_ab_in;         // product sign
    logic [15:0] c_in;               // binary16 addend
    logic [21:0] mantissa_ab_c_out;  // aligned sum significand, 2.20
    logic [4:0]  exp_ab_c_out;       // result exponent before normalization
    logic [4:0]  mantissa_shift_out; // left-shift count for normalizer
    logic        sign_out;           // result sign
    logic        fma_byp_out;        // addend-zero bypass flag
    logic        rounder_start;      // one-cycle result-valid pulse
    logic        busy;               // stage occupied

    modport master (
        output align_start, mantissa_ab_in, exp_ab_in, sign_ab_in, c_in,
        input  mantissa_ab_c_out, exp_ab_c_out, mantissa_shift_out,
               sign_out, fma_byp_out, rounder_start, busy
    );

    modport slave (
        input  align_start, mantissa_ab_in, exp_ab_in, sign_ab_in, c_in,
        output mantissa_ab_c_out, exp_ab_c_out, mantissa_shift_out,
               sign_out, fma_byp_out, rounder_start, busy
    );
endinterface
`default_nettype wire

// File: rtl/fma_align_add.sv
`default_nettype none
// ============================================================================
//  Module   : fma_align_add
//  Purpose  : Aligns a multiplier product against a binary16 addend, adds or
//             subtracts them and computes the left-shift count for the
//             downstream normalizer. Fixed five-state sequence:
//             IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
//  Ports    : clk  - single clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - fma_align_add_if.slave: operands in, results and
//                    rounder_start / busy out
//  Revision : 1.0 - initial release
// ============================================================================
module fma_align_add (
    input  logic           clk,
    input  logic           rst,
    fma_align_add_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ALIGN = 3'd1;
    localparam logic [2:0] c_ST_ADD   = 3'd2;
    localparam logic [2:0] c_ST_NORM  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [4:0] c_EXP_MAX  = 5'd31;
    localparam logic [4:0] c_MAN_W    = 5'd22;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;

    // Operands captured on acceptance
    logic [21:0] r_man_ab;
    logic [4:0]  r_exp_ab;
    logic        r_sign_ab;
    logic [15:0] r_c;

    // ALIGN -> ADD
    logic [21:0] r_big;
    logic [21:0] r_small;
    logic [4:0]  r_res_exp;
    logic        r_big_sign;
    logic        r_eff_sub;
    logic        r_byp;

    // ADD -> NORM
    logic [21:0] r_sum;
    logic [4:0]  r_sum_exp;
    logic        r_sum_sign;

    // Output registers
    logic [21:0] r_man_out;
    logic [4:0]  r_exp_out;
    logic [4:0]  r_shift_out;
    logic        r_sign_out;
    logic        r_byp_out;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.align_start) w_state_next = c_ST_ALIGN;
            c_ST_ALIGN: w_state_next = c_ST_ADD;
            c_ST_ADD:   w_state_next = c_ST_NORM;
            c_ST_NORM:  w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // ALIGN datapath (works on the captured operands)
    // ------------------------------------------------------------------
    logic        w_prod_ovf;
    logic [21:0] w_prod_man;
    logic [4:0]  w_prod_exp;
    logic [4:0]  w_add_exp;
    logic [21:0] w_add_man;
    logic        w_byp;
    logic        w_prod_big;
    logic [21:0] w_big_man;
    logic [21:0] w_small_raw;
    logic [4:0]  w_big_exp;
    logic [4:0]  w_small_exp;
    logic        w_big_sign;
    logic        w_small_sign;
    logic [4:0]  w_exp_diff;
    logic [21:0] w_small_shifted;

    // A product of 2.0 or more is pulled back into [1,2); the exponent
    // sticks at the top code rather than wrapping.
    assign w_prod_ovf = r_man_ab[21];
    assign w_prod_man = w_prod_ovf ? {1'b0, r_man_ab[21:1]} : r_man_ab;
    assign w_prod_exp = !w_prod_ovf           ? r_exp_ab :
                        (r_exp_ab == c_EXP_MAX) ? c_EXP_MAX : r_exp_ab + 5'd1;

    // Addend lands in the same 2.20 format; subnormals carry no hidden bit.
    assign w_add_exp = r_c[14:10];
    assign w_add_man = {1'b0, (w_add_exp != 5'd0), r_c[9:0], 10'd0};
    assign w_byp     = (r_c[14:0] == 15'd0);

    // Product wins full ties so a zero addend always leaves it untouched.
    assign w_prod_big = (w_prod_exp > w_add_exp) ||
                        ((w_prod_exp == w_add_exp) && (w_prod_man >= w_add_man));

    assign w_big_man    = w_prod_big ? w_prod_man : w_add_man;
    assign w_small_raw  = w_prod_big ? w_add_man  : w_prod_man;
    assign w_big_exp    = w_prod_big ? w_prod_exp : w_add_exp;
    assign w_small_exp  = w_prod_big ? w_add_exp  : w_prod_exp;
    assign w_big_sign   = w_prod_big ? r_sign_ab  : r_c[15];
    assign w_small_sign = w_prod_big ? r_c[15]    : r_sign_ab;

    assign w_exp_diff      = w_big_exp - w_small_exp;
    assign w_small_shifted = (w_exp_diff >= c_MAN_W) ? 22'd0 : (w_small_raw >> w_exp_diff);

    // ------------------------------------------------------------------
    // ADD datapath. Both operands are below 2.0, so the sum never needs
    // more than 22 bits; the big operand is never smaller, so no borrow.
    // ------------------------------------------------------------------
    logic [21:0] w_sum;
    logic        w_sum_zero;

    assign w_sum      = r_eff_sub ? (r_big - r_small) : (r_big + r_small);
    // Bypass keeps the product's own sign/exponent even for a zero product.
    assign w_sum_zero = (w_sum == 22'd0) && !r_byp;

    // ------------------------------------------------------------------
    // NORM datapath: leading-zero count below the integer bit, clamped so
    // the normalizer never drives the exponent below zero.
    // ------------------------------------------------------------------
    logic [4:0] w_lzc;
    logic [4:0] w_shift;

    always_comb begin
        w_lzc = 5'd21;
        for (int i = 0; i < 21; i++) begin
            if (r_sum[i]) w_lzc = 5'(20 - i);
        end
    end

    assign w_shift = (r_byp || (r_sum == 22'd0) || r_sum[21]) ? 5'd0 :
                     (w_lzc < r_sum_exp) ? w_lzc : r_sum_exp;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_man_ab    <= '0;
            r_exp_ab    <= '0;
            r_sign_ab   <= 1'b0;
            r_c         <= '0;
            r_big       <= '0;
            r_small     <= '0;
            r_res_exp   <= '0;
            r_big_sign  <= 1'b0;
            r_eff_sub   <= 1'b0;
            r_byp       <= 1'b0;
            r_sum       <= '0;
            r_sum_exp   <= '0;
            r_sum_sign  <= 1'b0;
            r_man_out   <= '0;
            r_exp_out   <= '0;
            r_shift_out <= '0;
            r_sign_out  <= 1'b0;
            r_byp_out   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.align_start) begin
                        r_man_ab  <= bus.mantissa_ab_in;
                        r_exp_ab  <= bus.exp_ab_in;
                        r_sign_ab <= bus.sign_ab_in;
                        r_c       <= bus.c_in;
                    end
                end
                c_ST_ALIGN: begin
                    r_big      <= w_big_man;
                    r_small    <= w_small_shifted;
                    r_res_exp  <= w_big_exp;
                    r_big_sign <= w_big_sign;
                    r_eff_sub  <= w_big_sign ^ w_small_sign;
                    r_byp      <= w_byp;
                end
                c_ST_ADD: begin
                    r_sum      <= w_sum;
                    r_sum_exp  <= w_sum_zero ? 5'd0 : r_res_exp;
                    r_sum_sign <= w_sum_zero ? 1'b0 : r_big_sign;
                end
                c_ST_NORM: begin
                    r_man_out   <= r_sum;
                    r_exp_out   <= r_sum_exp;
                    r_shift_out <= w_shift;
                    r_sign_out  <= r_sum_sign;
                    r_byp_out   <= r_byp;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mantissa_ab_c_out  = r_man_out;
    assign bus.exp_ab_c_out       = r_exp_out;
    assign bus.mantissa_shift_out = r_shift_out;
    assign bus.sign_out           = r_sign_out;
    assign bus.fma_byp_out        = r_byp_out;
    assign bus.rounder_start      = (r_state == c_ST_DONE);
    assign bus.busy               = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fma_align_add.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fma_align_add
//  Purpose  : Directed self-checking bench for fma_align_add: reset values,
//             arithmetic vectors, bypass, ignored starts, back-to-back jobs
//             and reset in mid-job.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fma_align_add;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fma_align_add_if bus ();

    fma_align_add dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [21:0] man;
        logic [4:0]  exp;
        logic        sign;
        logic [15:0] c;
        logic [21:0] e_man;
        logic [4:0]  e_exp;
        logic [4:0]  e_shift;
        logic        e_sign;
        logic        e_byp;
    } vec_t;

    // Drives one job and returns how many negedges after the accepting edge
    // rounder_start was first seen (0 when it never appeared).
    task automatic run_job(input logic [21:0] man, input logic [4:0] exp,
                           input logic sign, input logic [15:0] c,
                           output int lat);
        @(negedge clk);
        bus.mantissa_ab_in = man;
        bus.exp_ab_in      = exp;
        bus.sign_ab_in     = sign;
        bus.c_in           = c;
        bus.align_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.align_start = 1'b0;
        lat = 1;
        while (bus.rounder_start !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (bus.rounder_start !== 1'b1) lat = 0;
    endtask

    task automatic test_reset;
        rst                = 1'b1;
        bus.align_start    = 1'b0;
        bus.mantissa_ab_in = '0;
        bus.exp_ab_in      = '0;
        bus.sign_ab_in     = 1'b0;
        bus.c_in           = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mantissa_ab_c_out, bus.exp_ab_c_out, bus.mantissa_shift_out,
             bus.sign_out, bus.fma_byp_out, bus.rounder_start, bus.busy} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got man=%h exp=%h sh=%h s=%b byp=%b rs=%b busy=%b required all 0",
                     bus.mantissa_ab_c_out, bus.exp_ab_c_out, bus.mantissa_shift_out,
                     bus.sign_out, bus.fma_byp_out, bus.rounder_start, bus.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        vec_t vecs[$];
        int   lat;
        vecs.push_back('{"one_plus_one",  22'h100000, 5'd15, 1'b0, 16'h3C00, 22'h200000, 5'd15, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{"cancel",        22'h100000, 5'd15, 1'b0, 16'hBC00, 22'h000000, 5'd0,  5'd0, 1'b0, 1'b0});
        vecs.push_back('{"small_addend",  22'h100000, 5'd15, 1'b0, 16'h0400, 22'h100040, 5'd15, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{"sub_norm",      22'h180000, 5'd15, 1'b0, 16'hBD00, 22'h040000, 5'd15, 5'd2, 1'b0, 1'b0});
        vecs.push_back('{"addend_big",    22'h100000, 5'd10, 1'b0, 16'h3C00, 22'h108000, 5'd15, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{"addend_big_neg",22'h100000, 5'd10, 1'b0, 16'hBC00, 22'h0F8000, 5'd15, 5'd1, 1'b1, 1'b0});
        vecs.push_back('{"far_diff",      22'h100000, 5'd31, 1'b0, 16'h0400, 22'h100000, 5'd31, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{"diff20",        22'h100000, 5'd1,  1'b1, 16'h5400, 22'h0FFFFF, 5'd21, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{"exp_limit",     22'h180000, 5'd1,  1'b0, 16'h8500, 22'h040000, 5'd1,  5'd1, 1'b0, 1'b0});
        vecs.push_back('{"denorm_c",      22'h000000, 5'd0,  1'b0, 16'h8001, 22'h000400, 5'd0,  5'd0, 1'b1, 1'b0});
        vecs.push_back('{"prod_ovf_add",  22'h300000, 5'd14, 1'b0, 16'h3C00, 22'h280000, 5'd15, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{"tie_addend_big",22'h100000, 5'd15, 1'b0, 16'hBD00, 22'h040000, 5'd15, 5'd2, 1'b1, 1'b0});
        vecs.push_back('{"byp_ovf",       22'h200000, 5'd15, 1'b0, 16'h0000, 22'h100000, 5'd16, 5'd0, 1'b0, 1'b1});
        vecs.push_back('{"byp_sat",       22'h200000, 5'd31, 1'b1, 16'h8000, 22'h100000, 5'd31, 5'd0, 1'b1, 1'b1});
        vecs.push_back('{"byp_nonorm",    22'h040000, 5'd15, 1'b0, 16'h0000, 22'h040000, 5'd15, 5'd0, 1'b0, 1'b1});
        foreach (vecs[i]) begin
            run_job(vecs[i].man, vecs[i].exp, vecs[i].sign, vecs[i].c, lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL %s_latency: got %0d required 4", vecs[i].name, lat);
            end
            checks++;
            if (bus.mantissa_ab_c_out !== vecs[i].e_man) begin
                errors++;
                $display("FAIL %s_mantissa: got %h required %h", vecs[i].name, bus.mantissa_ab_c_out, vecs[i].e_man);
            end
            checks++;
            if (bus.exp_ab_c_out !== vecs[i].e_exp) begin
                errors++;
                $display("FAIL %s_exp: got %0d required %0d", vecs[i].name, bus.exp_ab_c_out, vecs[i].e_exp);
            end
            checks++;
            if (bus.mantissa_shift_out !== vecs[i].e_shift) begin
                errors++;
                $display("FAIL %s_shift: got %0d required %0d", vecs[i].name, bus.mantissa_shift_out, vecs[i].e_shift);
            end
            checks++;
            if (bus.sign_out !== vecs[i].e_sign) begin
                errors++;
                $display("FAIL %s_sign: got %b required %b", vecs[i].name, bus.sign_out, vecs[i].e_sign);
            end
            checks++;
            if (bus.fma_byp_out !== vecs[i].e_byp) begin
                errors++;
                $display("FAIL %s_byp: got %b required %b", vecs[i].name, bus.fma_byp_out, vecs[i].e_byp);
            end
            @(negedge clk);
            checks++;
            if (bus.rounder_start !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_pulse_end: got rs=%b busy=%b required 0 0", vecs[i].name, bus.rounder_start, bus.busy);
            end
        end
    endtask

    // align_start held high while busy must not start a second job.
    task automatic test_ignore_start;
        @(negedge clk);
        bus.mantissa_ab_in = 22'h100000;
        bus.exp_ab_in      = 5'd10;
        bus.sign_ab_in     = 1'b0;
        bus.c_in           = 16'hBC00;
        bus.align_start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rounder_start !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore_busy_k%0d: got rs=%b busy=%b required 0 1", k, bus.rounder_start, bus.busy);
            end
        end
        @(negedge clk);
        bus.align_start = 1'b0;
        checks++;
        if (bus.rounder_start !== 1'b1 || bus.mantissa_ab_c_out !== 22'h0F8000) begin
            errors++;
            $display("FAIL ignore_done: got rs=%b man=%h required 1 0f8000", bus.rounder_start, bus.mantissa_ab_c_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rounder_start !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_rerun: got busy=%b rs=%b required 0 0", bus.busy, bus.rounder_start);
        end
        checks++;
        if (bus.mantissa_ab_c_out !== 22'h0F8000 || bus.exp_ab_c_out !== 5'd15 ||
            bus.mantissa_shift_out !== 5'd1 || bus.sign_out !== 1'b1) begin
            errors++;
            $display("FAIL ignore_hold: got man=%h exp=%0d sh=%0d s=%b required 0f8000 15 1 1",
                     bus.mantissa_ab_c_out, bus.exp_ab_c_out, bus.mantissa_shift_out, bus.sign_out);
        end
    endtask

    // Start held high continuously: second job is taken one cycle after DONE,
    // and operand changes during the first job do not disturb it.
    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        bus.mantissa_ab_in = 22'h100000;
        bus.exp_ab_in      = 5'd15;
        bus.sign_ab_in     = 1'b0;
        bus.c_in           = 16'h0400;
        bus.align_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mantissa_ab_in = 22'h180000;
        bus.c_in           = 16'hBD00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rounder_start !== 1'b1 || bus.mantissa_ab_c_out !== 22'h100040) begin
            errors++;
            $display("FAIL b2b_first: got rs=%b man=%h required 1 100040", bus.rounder_start, bus.mantissa_ab_c_out);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got busy=%b required 0", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start: got busy=%b required 1", bus.busy);
        end
        bus.align_start = 1'b0;
        lat = 1;
        while (bus.rounder_start !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d required 4", lat);
        end
        checks++;
        if (bus.mantissa_ab_c_out !== 22'h040000 || bus.mantissa_shift_out !== 5'd2) begin
            errors++;
            $display("FAIL b2b_second_data: got man=%h sh=%0d required 040000 2",
                     bus.mantissa_ab_c_out, bus.mantissa_shift_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job;
        int seen;
        int lat;
        @(negedge clk);
        bus.mantissa_ab_in = 22'h100000;
        bus.exp_ab_in      = 5'd10;
        bus.sign_ab_in     = 1'b0;
        bus.c_in           = 16'h3C00;
        bus.align_start    = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mantissa_ab_c_out, bus.exp_ab_c_out, bus.mantissa_shift_out,
             bus.sign_out, bus.fma_byp_out, bus.rounder_start, bus.busy} !== 36'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got man=%h exp=%h sh=%h s=%b byp=%b rs=%b busy=%b required all 0",
                     bus.mantissa_ab_c_out, bus.exp_ab_c_out, bus.mantissa_shift_out,
                     bus.sign_out, bus.fma_byp_out, bus.rounder_start, bus.busy);
        end
        rst             = 1'b0;
        bus.align_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rounder_start === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_pulse: got %0d active cycles required 0", seen);
        end
        run_job(22'h100000, 5'd15, 1'b0, 16'h3C00, lat);
        checks++;
        if (lat !== 4 || bus.mantissa_ab_c_out !== 22'h200000 || bus.exp_ab_c_out !== 5'd15) begin
            errors++;
            $display("FAIL midrst_recover: got lat=%0d man=%h exp=%0d required 4 200000 15",
                     lat, bus.mantissa_ab_c_out, bus.exp_ab_c_out);
        end
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
